// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit owning HI/LO; busy for a fixed latency per op.
// Optional accumulate ops (madd/maddu, op 110/111) are built only when MDU_MADD_EN is defined.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] d1,
  input  logic [31:0] d2,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state;
  logic [3:0]  count;
  logic [31:0] pending_hi, pending_lo;

  logic [63:0] prod_s, prod_u, res;
  logic [31:0] d2_safe, quot_s, rem_s, quot_u, rem_u;
  logic        div_ovf;
  logic [3:0]  lat;

  always_comb begin
    prod_s  = $signed({{32{d1[31]}}, d1}) * $signed({{32{d2[31]}}, d2});
    prod_u  = {32'b0, d1} * {32'b0, d2};
    div_ovf = (d1 == 32'h8000_0000) && (d2 == 32'hFFFF_FFFF);
    // Divider only sees a safe divisor; zero and overflow results are chosen below.
    d2_safe = (d2 == 32'b0 || div_ovf) ? 32'd1 : d2;
    quot_s  = $signed(d1) / $signed(d2_safe);
    rem_s   = $signed(d1) % $signed(d2_safe);
    quot_u  = d1 / d2_safe;
    rem_u   = d1 % d2_safe;
    res     = {hi, lo};
    lat     = 4'd0;
    case (op)
      3'b000: begin res = prod_s; lat = 4'(MULT_CYCLES); end
      3'b001: begin res = prod_u; lat = 4'(MULT_CYCLES); end
      3'b010: begin
        if (d2 != 32'b0) res = div_ovf ? {32'b0, 32'h8000_0000} : {rem_s, quot_s};
        lat = 4'(DIV_CYCLES);
      end
      3'b011: begin
        if (d2 != 32'b0) res = {rem_u, quot_u};
        lat = 4'(DIV_CYCLES);
      end
`ifdef MDU_MADD_EN
      3'b110: begin res = {hi, lo} + prod_s; lat = 4'(MULT_CYCLES); end
      3'b111: begin res = {hi, lo} + prod_u; lat = 4'(MULT_CYCLES); end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      hi         <= 32'b0;
      lo         <= 32'b0;
      count      <= 4'd0;
      pending_hi <= 32'b0;
      pending_lo <= 32'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (op == 3'b100)      hi <= d1;
          else if (op == 3'b101) lo <= d1;
          else if (lat != 4'd0) begin
            pending_hi <= res[63:32];
            pending_lo <= res[31:0];
            count      <= lat;
            busy       <= 1'b1;
            state      <= RUN;
          end
        end
        RUN: begin
          // start is ignored here; only the countdown advances.
          if (count == 4'd1) begin
            hi    <= pending_hi;
            lo    <= pending_lo;
            busy  <= 1'b0;
            count <= 4'd0;
            state <= IDLE;
          end else begin
            count <= count - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against an arithmetic HI/LO model.
module tb_mult_div_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  op;
  logic [31:0] d1, d2;
  logic        busy;
  logic [31:0] hi, lo;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_hi, m_lo;

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .d1(d1), .d2(d2),
    .busy(busy), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Architectural result of one issued op; lat=0 means no busy period.
  task automatic model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int lat);
    longint      q, r;
    logic [63:0] p;
    lat = 0;
    case (o)
      3'd0: begin p = 64'(longint'($signed(a)) * longint'($signed(b))); {m_hi, m_lo} = p; lat = MC; end
      3'd1: begin p = {32'b0, a} * {32'b0, b}; {m_hi, m_lo} = p; lat = MC; end
      3'd2: begin
        if (b != 0) begin
          q = longint'($signed(a)) / longint'($signed(b));
          r = longint'($signed(a)) % longint'($signed(b));
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        lat = DC;
      end
      3'd3: begin
        if (b != 0) begin m_lo = a / b; m_hi = a % b; end
        lat = DC;
      end
      3'd4: m_hi = a;
      3'd5: m_lo = a;
`ifdef MDU_MADD_EN
      3'd6: begin
        p = {m_hi, m_lo} + 64'(longint'($signed(a)) * longint'($signed(b)));
        {m_hi, m_lo} = p; lat = MC;
      end
      3'd7: begin
        p = {m_hi, m_lo} + {32'b0, a} * {32'b0, b};
        {m_hi, m_lo} = p; lat = MC;
      end
`endif
      default: ;
    endcase
  endtask

  // Issue one op; optionally pulse an mtlo of 0x55 during busy cycle intr.
  task automatic do_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                       input logic [31:0] b, input int intr);
    int lat, cnt;
    logic [31:0] old_hi, old_lo;
    old_hi = m_hi; old_lo = m_lo;
    model(o, a, b, lat);
    @(negedge clk);
    start = 1'b1; op = o; d1 = a; d2 = b;
    @(negedge clk);
    start = 1'b0;
    if (lat == 0) begin
      chk({tag, ".busy"}, 64'(busy), 64'd0);
    end else begin
      chk({tag, ".hold"}, {hi, lo}, {old_hi, old_lo});
      cnt = 0;
      while (busy === 1'b1 && cnt < 40) begin
        cnt++;
        if (cnt == intr) begin start = 1'b1; op = 3'd5; d1 = 32'h55; end
        else start = 1'b0;
        @(negedge clk);
      end
      start = 1'b0;
      chk({tag, ".lat"}, 64'(cnt), 64'(lat));
    end
    chk({tag, ".hilo"}, {hi, lo}, {m_hi, m_lo});
  endtask

  initial begin
    int sel;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; op = 3'd0; d1 = 32'd0; d2 = 32'd0;
    m_hi = 32'd0; m_lo = 32'd0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst.busy", 64'(busy), 64'd0);
    chk("rst.hilo", {hi, lo}, 64'd0);

    do_op("mult",  3'd0, 32'hFFFF_FFFE, 32'd3, 0);
    chk("mult.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);
    do_op("multu", 3'd1, 32'hFFFF_FFFF, 32'd2, 0);
    chk("multu.const", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    do_op("div",   3'd2, 32'hFFFF_FFF9, 32'd2, 0);
    chk("div.const", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    do_op("divu",  3'd3, 32'd100, 32'd7, 0);
    chk("divu.const", {hi, lo}, {32'd2, 32'd14});
    do_op("div0",  3'd2, 32'd5, 32'd0, 0);
    chk("div0.const", {hi, lo}, {32'd2, 32'd14});
    do_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    chk("divovf.const", {hi, lo}, {32'd0, 32'h8000_0000});
    do_op("mthi", 3'd4, 32'h1234, 32'd0, 0);
    do_op("mtlo", 3'd5, 32'hABCD, 32'd0, 0);
    chk("mtx.const", {hi, lo}, {32'h1234, 32'hABCD});
    do_op("ign", 3'd0, 32'd2, 32'd3, 2);
    chk("ign.const", {hi, lo}, {32'd0, 32'd6});

    // Reset during busy cycle 4 of a divu discards the result.
    @(negedge clk);
    start = 1'b1; op = 3'd3; d1 = 32'd9; d2 = 32'd2;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    chk("rstmid.busy", 64'(busy), 64'd0);
    chk("rstmid.hilo", {hi, lo}, 64'd0);
    repeat (12) @(negedge clk);
    chk("rstmid.late", {busy, hi, lo}, 65'd0);
    do_op("mult44", 3'd0, 32'd4, 32'd4, 0);
    chk("mult44.const", {hi, lo}, 64'd16);

    do_op("mtlo10", 3'd5, 32'd10, 32'd0, 0);
    do_op("mthi0",  3'd4, 32'd0,  32'd0, 0);
    do_op("madd",   3'd6, 32'hFFFF_FFFF, 32'd3, 0);
`ifdef MDU_MADD_EN
    chk("madd.const", {hi, lo}, 64'd7);
`else
    chk("madd.const", {hi, lo}, 64'd10);
`endif

    for (int i = 0; i < 40; i++) begin
      sel = int'($urandom_range(0, 3));
      a = $urandom;
      case (sel)
        0: b = 32'd0;
        1: b = $urandom_range(1, 9);
        default: b = $urandom;
      endcase
      do_op("rnd", 3'($urandom_range(0, 7)), a, b, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: sim did not finish, bad=%0d", bad);
    $fatal(1);
  end
endmodule
